dma_ext_device: RTL and testbench

Model of the external I/O device that is the data source for the DMA controller. It holds a 12-word buffer, loaded by the testbench or the system. After a programmable delay it raises a one-cycle DMA-begin interrupt to the CPU. While the DMA controller owns the bus, it drives buffer words selected by the controller's index, and it checks on DMA completion that exactly one full buffer was transferred.

---
 rtl/dma_ext_device.sv | 100 ++++++++++
 tb/tb_dma_ext_device.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_ext_device.sv
// External I/O device feeding the DMA controller: a small word buffer, an armed
// countdown that raises dma_begin, and a beat audit checked when the DMA finishes.
module dma_ext_device #(
  parameter int WORD_SIZE     = 16,
  parameter int BUF_DEPTH     = 12,
  parameter int TRIGGER_DELAY = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_en,
  input  logic [3:0]           load_idx,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 arm,
  input  logic                 use_bus,
  input  logic [3:0]           idx,
  input  logic                 dma_end,
  output logic [WORD_SIZE-1:0] data,
  output logic                 dma_begin,
  output logic [3:0]           dma_length,
  output logic                 busy,
  output logic                 xfer_err
);

  localparam int             CW         = $clog2(TRIGGER_DELAY) + 1;
  localparam logic [3:0]     DEPTH4     = 4'(BUF_DEPTH);
  localparam logic [CW-1:0]  DELAY_INIT = CW'(TRIGGER_DELAY - 1);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, XFER} state_t;

  state_t               state, state_next;
  logic [WORD_SIZE-1:0] buf_mem [BUF_DEPTH];
  logic [CW-1:0]        delay_cnt;
  logic [3:0]           beat_cnt;
  logic [3:0]           beat_total;
  logic                 in_range;

  assign in_range   = (idx < DEPTH4);
  assign busy       = (state != IDLE);
  assign dma_length = DEPTH4;

  // Beat count including a beat presented this very cycle, saturating at 15.
  assign beat_total = (use_bus && beat_cnt != 4'hF) ? beat_cnt + 4'd1 : beat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = COUNT;
      COUNT:   if (delay_cnt == '0) state_next = FIRE;
      FIRE:    state_next = XFER;
      XFER:    if (dma_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The buffer is only writable while idle so a transfer always sees stable words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else if (state == IDLE && load_en && load_idx < DEPTH4) begin
      buf_mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delay_cnt <= '0;
      beat_cnt  <= '0;
      data      <= '0;
      dma_begin <= 1'b0;
      xfer_err  <= 1'b0;
    end else begin
      dma_begin <= (state_next == FIRE);
      data      <= (state == XFER && use_bus && in_range) ? buf_mem[idx] : '0;
      case (state)
        IDLE: begin
          if (arm) begin
            delay_cnt <= DELAY_INIT;
            xfer_err  <= 1'b0;
          end
        end
        COUNT: begin
          if (delay_cnt != '0) delay_cnt <= delay_cnt - CW'(1);
        end
        FIRE: beat_cnt <= '0;
        XFER: begin
          if (use_bus) beat_cnt <= beat_total;
          if ((use_bus && !in_range) || (dma_end && beat_total != DEPTH4))
            xfer_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ext_device.sv
// Bench for dma_ext_device: an edge-count based reference model checked every cycle,
// plus directed load/fire/transfer/reset scenarios with literal expectations.
module tb_dma_ext_device;

  localparam int WS    = 16;
  localparam int DEPTH = 12;
  localparam int TD    = 200;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_en, arm, use_bus, dma_end;
  logic [3:0]    load_idx, idx;
  logic [WS-1:0] load_data;
  logic [WS-1:0] data;
  logic          dma_begin, busy, xfer_err;
  logic [3:0]    dma_length;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_ext_device #(.WORD_SIZE(WS), .BUF_DEPTH(DEPTH), .TRIGGER_DELAY(TD)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .arm(arm), .use_bus(use_bus), .idx(idx),
    .dma_end(dma_end), .data(data), .dma_begin(dma_begin),
    .dma_length(dma_length), .busy(busy), .xfer_err(xfer_err)
  );

  // Reference model: time is measured in edges since the accepted arm.
  logic [WS-1:0] m_buf [DEPTH];
  logic [WS-1:0] m_data;
  logic          m_active, m_err, m_begin;
  int            n, m_arm_edge, m_beats;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n <= 0; m_arm_edge <= 0; m_beats <= 0;
      m_active <= 1'b0; m_err <= 1'b0; m_begin <= 1'b0; m_data <= '0;
      for (int i = 0; i < DEPTH; i++) m_buf[i] <= '0;
    end else begin
      n       <= n + 1;
      m_data  <= '0;
      m_begin <= 1'b0;
      if (!m_active) begin
        if (load_en && load_idx < DEPTH) m_buf[load_idx] <= load_data;
        if (arm) begin
          m_active <= 1'b1; m_arm_edge <= n; m_err <= 1'b0; m_beats <= 0;
        end
      end else begin
        if (n - m_arm_edge == TD) m_begin <= 1'b1;
        if (n - m_arm_edge >= TD + 2) begin
          if (use_bus) begin
            m_beats <= m_beats + 1;
            if (idx < DEPTH) m_data <= m_buf[idx];
            else             m_err  <= 1'b1;
          end
          if (dma_end) begin
            if (m_beats + (use_bus ? 1 : 0) != DEPTH) m_err <= 1'b1;
            m_active <= 1'b0;
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check_output("data",       data,       m_data);
      check_output("dma_begin",  dma_begin,  m_begin);
      check_output("busy",       busy,       m_active);
      check_output("xfer_err",   xfer_err,   m_err);
      check_output("dma_length", dma_length, 32'(DEPTH));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic apply_beat(input logic [3:0] i, input logic with_end);
    use_bus = 1'b1; idx = i; dma_end = with_end;
    step();
    use_bus = 1'b0; idx = '0; dma_end = 1'b0;
  endtask

  // Waits (bounded) for dma_begin, optionally poking inputs that COUNT must ignore.
  task automatic wait_begin(input string tag, input bit inject);
    int j = 0;
    while (dma_begin !== 1'b1 && j < TD + 50) begin
      if (inject) begin
        case (j)
          5:  begin load_en = 1'b1; load_idx = 4'd3; load_data = 16'hFFFF; end
          6:  load_en = 1'b0;
          10: arm = 1'b1;
          11: arm = 1'b0;
          20: begin use_bus = 1'b1; idx = 4'd0; end
          21: use_bus = 1'b0;
          default: ;
        endcase
      end
      step();
      j++;
    end
    check_output({tag, " begin latency"}, j, TD);
    step();
    check_output({tag, " begin one cycle"}, dma_begin, 1'b0);
  endtask

  initial begin
    load_en = 0; arm = 0; use_bus = 0; dma_end = 0;
    load_idx = '0; idx = '0; load_data = '0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    check_output("reset busy",       busy,       1'b0);
    check_output("reset data",       data,       16'h0);
    check_output("reset err",        xfer_err,   1'b0);
    check_output("reset dma_length", dma_length, 4'd12);

    // Out-of-range load first, then the real buffer, arming on the last word.
    load_en = 1'b1; load_idx = 4'd12; load_data = 16'hBEEF;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_idx = 4'(i); load_data = 16'(16'h1000 + i);
      arm = (i == DEPTH - 1);
      step();
    end
    load_en = 1'b0; arm = 1'b0;
    check_output("busy after arm", busy, 1'b1);

    wait_begin("run1", 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      arm = (i == 5);
      apply_beat(4'(i), 1'b0);
      arm = 1'b0;
      check_output("clean data", data, 32'(16'h1000 + i));
    end
    dma_end = 1'b1;
    step();
    dma_end = 1'b0;
    check_output("clean err",  xfer_err, 1'b0);
    check_output("clean idle", busy,     1'b0);

    // Short transfer: eleventh beat arrives together with dma_end.
    apply_arm();
    wait_begin("run2", 1'b0);
    for (int i = 0; i < DEPTH - 2; i++) apply_beat(4'(i), 1'b0);
    apply_beat(4'(DEPTH - 2), 1'b1);
    check_output("short err",  xfer_err, 1'b1);
    check_output("short idle", busy,     1'b0);
    repeat (3) step();
    check_output("short err sticky", xfer_err, 1'b1);
    apply_arm();
    check_output("err cleared by arm", xfer_err, 1'b0);

    wait_begin("run3", 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      apply_beat(4'(i), 1'b0);
      if (i == 3) check_output("buf3 unchanged", data, 16'h1003);
    end
    apply_beat(4'd12, 1'b0);
    check_output("oob data", data,     16'h0);
    check_output("oob err",  xfer_err, 1'b1);
    dma_end = 1'b1;
    step();
    dma_end = 1'b0;
    check_output("oob err after end", xfer_err, 1'b1);

    // Asynchronous reset in the middle of a transfer.
    apply_arm();
    wait_begin("run4", 1'b0);
    apply_beat(4'd12, 1'b0);
    apply_beat(4'd1, 1'b0);
    check_output("pre-reset data", data,     16'h1001);
    check_output("pre-reset err",  xfer_err, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_output("async reset busy",  busy,      1'b0);
    check_output("async reset begin", dma_begin, 1'b0);
    check_output("async reset err",   xfer_err,  1'b0);
    check_output("async reset data",  data,      16'h0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    check_output("post-reset idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
